// File: rtl/ir_nec_rx.sv
// rtl/ir_nec_rx.sv - NEC IR frame receiver with pulse-width windows; IR_NEC_REPEAT_EN adds repeat-code detection
module ir_nec_rx #(
  parameter int CLK_HZ     = 50000000,
  parameter int TICK_HZ    = 1000000,
  parameter int INPUT_INV  = 1,
  parameter int FILT_LEN   = 3,
  parameter int LEAD_H_MIN = 8500,
  parameter int LEAD_H_MAX = 9500,
  parameter int LEAD_L_MIN = 4000,
  parameter int LEAD_L_MAX = 5000,
  parameter int BIT_H_MIN  = 400,
  parameter int BIT_H_MAX  = 800,
  parameter int BIT_SPLIT  = 1100,
  parameter int BIT_L_MAX  = 2000,
  parameter int RPT_L_MIN  = 2000,
  parameter int RPT_L_MAX  = 2750
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ir_rxb,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic        o_chk_ok,
  output logic        o_err,
`ifdef IR_NEC_REPEAT_EN
  output logic        o_repeat,
`endif
  output logic        o_busy
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int DIV_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic IDLE_RAW = (INPUT_INV != 0);

  localparam logic [31:0] C_LHMIN = 32'(LEAD_H_MIN);
  localparam logic [31:0] C_LHMAX = 32'(LEAD_H_MAX);
  localparam logic [31:0] C_LLMIN = 32'(LEAD_L_MIN);
  localparam logic [31:0] C_LLMAX = 32'(LEAD_L_MAX);
  localparam logic [31:0] C_BHMIN = 32'(BIT_H_MIN);
  localparam logic [31:0] C_BHMAX = 32'(BIT_H_MAX);
  localparam logic [31:0] C_SPLIT = 32'(BIT_SPLIT);
  localparam logic [31:0] C_BLMAX = 32'(BIT_L_MAX);

  typedef enum logic [3:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE,
    S_STOP, S_DONE, S_ERR, S_RPT_STOP
  } state_t;

  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_sync;
  logic             r_filt;
  logic [3:0]       r_fcnt;
  logic [15:0]      r_cnt;
  state_t           r_state;
  logic [31:0]      r_shift;
  logic [4:0]       r_bitcnt;
  logic [31:0]      r_data;
  logic             r_valid;
  logic             r_chk;
  logic             r_err;
`ifdef IR_NEC_REPEAT_EN
  logic             r_repeat;
  logic             r_seen;
`endif

  logic        w_tick;
  logic        w_lvl;
  logic        w_flip;
  logic        w_mark_edge;
  logic        w_space_edge;
  logic [15:0] w_cnt;
  logic [31:0] w_len;
  logic        w_lead_h_ok;
  logic        w_lead_l_ok;
  logic        w_bit_h_ok;

  assign w_tick       = (r_div == DIV_W'(TICK_DIV - 1));
  assign w_lvl        = (INPUT_INV != 0) ? ~r_sync[1] : r_sync[1];
  assign w_flip       = w_tick && (w_lvl != r_filt) && (r_fcnt == 4'(FILT_LEN - 1));
  assign w_mark_edge  = w_flip && !r_filt;
  assign w_space_edge = w_flip && r_filt;
  // Length of the current level including this tick; this is what edges and timeouts judge.
  assign w_cnt        = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  assign w_len        = {16'd0, w_cnt};
  assign w_lead_h_ok  = (w_len >= C_LHMIN) && (w_len <= C_LHMAX);
  assign w_lead_l_ok  = (w_len >= C_LLMIN) && (w_len <= C_LLMAX);
  assign w_bit_h_ok   = (w_len >= C_BHMIN) && (w_len <= C_BHMAX);

  // Tick enable divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  // Two-flop synchronizer, reset to the sensor's idle level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= {2{IDLE_RAW}};
    else        r_sync <= {r_sync[0], i_ir_rxb};
  end

  // Glitch filter: level flips after FILT_LEN consecutive opposite tick samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= 1'b0;
      r_fcnt <= '0;
    end else if (w_tick) begin
      if (w_lvl == r_filt) begin
        r_fcnt <= '0;
      end else if (w_flip) begin
        r_filt <= ~r_filt;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 4'd1;
      end
    end
  end

  // Saturating width counter, restarted on every filtered edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (w_tick) r_cnt <= w_flip ? 16'd0 : w_cnt;
  end

  // Frame decoder FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_chk    <= 1'b0;
      r_err    <= 1'b0;
`ifdef IR_NEC_REPEAT_EN
      r_repeat <= 1'b0;
      r_seen   <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
`ifdef IR_NEC_REPEAT_EN
      r_repeat <= 1'b0;
`endif
      case (r_state)
        S_DONE: begin
          r_data  <= r_shift;
          r_chk   <= (r_shift[15:8] == ~r_shift[7:0]);
          r_valid <= 1'b1;
          r_shift <= '0;
`ifdef IR_NEC_REPEAT_EN
          r_seen  <= 1'b1;
`endif
          r_state <= S_IDLE;
        end
        S_ERR: begin
          r_err   <= 1'b1;
          r_shift <= '0;
          r_state <= S_IDLE;
        end
        default: if (w_tick) begin
          case (r_state)
            S_IDLE: if (w_mark_edge) r_state <= S_LEAD_MARK;
            S_LEAD_MARK: begin
              if (w_space_edge)        r_state <= w_lead_h_ok ? S_LEAD_SPACE : S_ERR;
              else if (w_len > C_LHMAX) r_state <= S_ERR;
            end
            S_LEAD_SPACE: begin
              if (w_mark_edge) begin
                if (w_lead_l_ok) begin
                  r_state  <= S_BIT_MARK;
                  r_bitcnt <= '0;
`ifdef IR_NEC_REPEAT_EN
                end else if (r_seen && w_len >= 32'(RPT_L_MIN) && w_len <= 32'(RPT_L_MAX)) begin
                  r_state <= S_RPT_STOP;
`endif
                end else begin
                  r_state <= S_ERR;
                end
              end else if (w_len > C_LLMAX) begin
                r_state <= S_ERR;
              end
            end
            S_BIT_MARK: begin
              if (w_space_edge)         r_state <= w_bit_h_ok ? S_BIT_SPACE : S_ERR;
              else if (w_len > C_BHMAX) r_state <= S_ERR;
            end
            S_BIT_SPACE: begin
              if (w_len > C_BLMAX) begin
                r_state <= S_ERR;
              end else if (w_mark_edge) begin
                r_shift  <= {r_shift[30:0], (w_len >= C_SPLIT)};
                r_bitcnt <= r_bitcnt + 5'd1;
                r_state  <= (r_bitcnt == 5'd31) ? S_STOP : S_BIT_MARK;
              end
            end
            S_STOP: begin
              if (w_space_edge)         r_state <= w_bit_h_ok ? S_DONE : S_ERR;
              else if (w_len > C_BHMAX) r_state <= S_ERR;
            end
`ifdef IR_NEC_REPEAT_EN
            S_RPT_STOP: begin
              if (w_space_edge) begin
                r_repeat <= w_bit_h_ok;
                r_state  <= w_bit_h_ok ? S_IDLE : S_ERR;
              end else if (w_len > C_BHMAX) begin
                r_state <= S_ERR;
              end
            end
`endif
            default: r_state <= S_IDLE;
          endcase
        end
      endcase
    end
  end

  assign o_data   = r_data;
  assign o_valid  = r_valid;
  assign o_chk_ok = r_chk;
  assign o_err    = r_err;
  assign o_busy   = (r_state != S_IDLE);
`ifdef IR_NEC_REPEAT_EN
  assign o_repeat = r_repeat;
`endif

endmodule

// File: tb/tb_ir_nec_rx.sv
// tb/tb_ir_nec_rx.sv - self-checking bench for ir_nec_rx with timing windows scaled down by 50
module tb_ir_nec_rx;

  localparam int DIV = 2, FL = 3;
  localparam int LHMIN = 170, LHMAX = 190, LLMIN = 80, LLMAX = 100;
  localparam int BHMIN = 8, BHMAX = 16, SPLIT = 22, BLMAX = 40, RMIN = 40, RMAX = 55;
  localparam int T_LH = 180, T_LL = 90, T_M = 11, T_S0 = 11, T_S1 = 34, T_RL = 45;
  localparam int BIG = 100000;
  localparam int K_NONE = 0, K_VALID = 1, K_ERR = 2, K_RPT = 3;
  localparam int B_FAST = (FL + 2) * DIV + 4;
  localparam int B_TRUNC = (BLMAX + FL + 3) * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_ir_rxb = 1'b1;
  logic [31:0] o_data;
  logic        o_valid, o_chk_ok, o_err, o_busy;
`ifdef IR_NEC_REPEAT_EN
  logic        o_repeat;
`endif

  int          n_cmp = 0, n_fail = 0;
  int          exp_kind[$];
  logic [31:0] exp_data[$];
  logic [31:0] m_data = 32'd0;
  bit          m_seen = 1'b0;
  int          g_q[$];

  ir_nec_rx #(
    .CLK_HZ(2000000), .TICK_HZ(1000000), .INPUT_INV(1), .FILT_LEN(FL),
    .LEAD_H_MIN(LHMIN), .LEAD_H_MAX(LHMAX), .LEAD_L_MIN(LLMIN), .LEAD_L_MAX(LLMAX),
    .BIT_H_MIN(BHMIN), .BIT_H_MAX(BHMAX), .BIT_SPLIT(SPLIT), .BIT_L_MAX(BLMAX),
    .RPT_L_MIN(RMIN), .RPT_L_MAX(RMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_ir_rxb(i_ir_rxb),
    .o_data(o_data), .o_valid(o_valid), .o_chk_ok(o_chk_ok), .o_err(o_err),
`ifdef IR_NEC_REPEAT_EN
    .o_repeat(o_repeat),
`endif
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Outcome of one burst of alternating mark/space widths in g_q, judged by the frame rules
  function automatic int model(input bit seen, output logic [31:0] data);
    data = 32'd0;
    if (g_q[0] < LHMIN || g_q[0] > LHMAX) return K_ERR;
    if (g_q[1] >= LLMIN && g_q[1] <= LLMAX) begin
      for (int b = 0; b < 32; b++) begin
        if (g_q[2+2*b] < BHMIN || g_q[2+2*b] > BHMAX) return K_ERR;
        if (g_q[3+2*b] > BLMAX) return K_ERR;
        data = {data[30:0], (g_q[3+2*b] >= SPLIT)};
      end
      return (g_q[66] >= BHMIN && g_q[66] <= BHMAX) ? K_VALID : K_ERR;
    end
`ifdef IR_NEC_REPEAT_EN
    if (seen && g_q[1] >= RMIN && g_q[1] <= RMAX)
      return (g_q[2] >= BHMIN && g_q[2] <= BHMAX) ? K_RPT : K_ERR;
`endif
    return K_ERR;
  endfunction

  task automatic build(input logic [31:0] v);
    g_q.delete();
    g_q.push_back(T_LH);
    g_q.push_back(T_LL);
    for (int b = 31; b >= 0; b--) begin
      g_q.push_back(T_M);
      g_q.push_back(v[b] ? T_S1 : T_S0);
    end
    g_q.push_back(T_M);
    g_q.push_back(BIG);
  endtask

  task automatic drive(input bit mark, input int ticks);
    i_ir_rxb = ~mark;
    repeat (ticks * DIV) @(posedge clk);
    #1;
  endtask

  task automatic drive_glitch(input bit mark, input int ticks);
    drive(mark, ticks / 2);
    drive(!mark, 2);
    drive(mark, ticks - ticks / 2 - 2);
  endtask

  task automatic run(input bit glitch, input int budget);
    logic [31:0] d;
    int          k;
    k = model(m_seen, d);
    exp_kind.push_back(k);
    exp_data.push_back(d);
    for (int i = 0; i < g_q.size() - 1; i++) begin
      if (glitch) drive_glitch((i % 2) == 0, g_q[i]);
      else        drive((i % 2) == 0, g_q[i]);
    end
    i_ir_rxb = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      if (exp_kind.size() == 0) break;
    end
    #1;
    n_cmp++;
    if (exp_kind.size() != 0) begin
      n_fail++;
      $display("FAIL event_timeout: got %0d pending events want 0 within %0d clk", exp_kind.size(), budget);
      exp_kind.delete();
      exp_data.delete();
    end
    drive(1'b0, 60);
    check("busy_after_frame", o_busy, 0);
  endtask

  // Per-cycle comparison of DUT outputs against the model state
  always @(negedge clk) begin
    int   k;
    logic rp;
    rp = 1'b0;
`ifdef IR_NEC_REPEAT_EN
    rp = o_repeat;
`endif
    if (!rst_n) begin
      check("rst_data", o_data, 0);
      check("rst_flags", {27'd0, o_valid, o_chk_ok, o_err, o_busy, rp}, 0);
      exp_kind.delete();
      exp_data.delete();
      m_data = 32'd0;
      m_seen = 1'b0;
    end else begin
      check("valid_err_excl", {31'd0, o_valid && o_err}, 0);
      k = o_valid ? K_VALID : (o_err ? K_ERR : (rp ? K_RPT : K_NONE));
      if (k != K_NONE) begin
        if (exp_kind.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_event: got kind %0d want none", k);
        end else begin
          check("event_kind", k, exp_kind[0]);
          if (exp_kind[0] == K_VALID) begin
            m_data = exp_data[0];
            m_seen = 1'b1;
          end
          void'(exp_kind.pop_front());
          void'(exp_data.pop_front());
        end
      end
      check("data_track", o_data, m_data);
      check("chk_track", {31'd0, o_chk_ok}, {31'd0, m_data[15:8] == ~m_data[7:0]});
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish want finish before 5 ms");
    $fatal(1);
  end

  initial begin
    repeat (4) @(posedge clk);
    #1;
    check("reset_data", o_data, 0);
    check("reset_busy", {31'd0, o_busy}, 0);
    rst_n = 1'b1;
    drive(1'b0, 20);

`ifdef IR_NEC_REPEAT_EN
    g_q.delete(); g_q.push_back(T_LH); g_q.push_back(T_RL); g_q.push_back(T_M); g_q.push_back(BIG);
    run(1'b0, B_FAST);
`endif

    build(32'h00FF30CF);
    run(1'b0, B_FAST);
    check("frame1_data", o_data, 32'h00FF30CF);
    check("frame1_chk", {31'd0, o_chk_ok}, 1);

    build(32'h00FF3030);
    run(1'b0, B_FAST);
    check("frame2_data", o_data, 32'h00FF3030);
    check("frame2_chk", {31'd0, o_chk_ok}, 0);

`ifdef IR_NEC_REPEAT_EN
    g_q.delete(); g_q.push_back(T_LH); g_q.push_back(T_RL); g_q.push_back(T_M); g_q.push_back(BIG);
    run(1'b0, B_FAST);
    check("repeat_data_held", o_data, 32'h00FF3030);
`endif

    g_q.delete(); g_q.push_back(140); g_q.push_back(BIG);
    run(1'b0, B_FAST);
    check("badlead_data_held", o_data, 32'h00FF3030);

    build(32'h20DF10EF);
    run(1'b0, B_FAST);
    check("recover_data", o_data, 32'h20DF10EF);

    build(32'h12345678);
    while (g_q.size() > 41) void'(g_q.pop_back());
    g_q.push_back(BIG);
    run(1'b0, B_TRUNC);
    check("trunc_data_held", o_data, 32'h20DF10EF);

    build(32'hA5A5F00F);
    run(1'b1, B_FAST);
    check("glitch_data", o_data, 32'hA5A5F00F);

    build(32'h12345678);
    for (int i = 0; i < 33; i++) drive((i % 2) == 0, g_q[i]);
    drive(1'b0, 5);
    rst_n = 1'b0;
    #1;
    check("midrst_data", o_data, 0);
    check("midrst_busy", {31'd0, o_busy}, 0);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 40);

    build(32'h00FF30CF);
    run(1'b0, B_FAST);
    check("after_rst_data", o_data, 32'h00FF30CF);
    check("after_rst_chk", {31'd0, o_chk_ok}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
